// File: rtl/dram_req_arbiter_pkg.sv
// dram_req_arbiter_pkg: FSM state encoding and DRAM user-port field widths
package dram_req_arbiter_pkg;

    localparam int ADDR_W  = 32;
    localparam int WDATA_W = 32;
    localparam int MASK_W  = 4;
    localparam int LINE_W  = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/dram_req_arbiter_rr_picker.sv
// dram_req_arbiter_rr_picker: round-robin winner search starting after the last owner
module dram_req_arbiter_rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic w_found;

    // Walk ptr+1 .. ptr+N_REQ with an explicit mod so non-power-of-2 counts never alias;
    // the last candidate is ptr itself, so the previous owner only wins when it is alone.
    always_comb begin
        w_found = 1'b0;
        o_gnt   = '0;
        o_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            automatic int k = (int'(i_ptr) + i) % N_REQ;
            if (!w_found && i_valid[k]) begin
                w_found  = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = IDX_W'(k);
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: round-robin sharing of a single-outstanding DRAM user port
module dram_req_arbiter
    import dram_req_arbiter_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                     i_clk,
    input  logic                     i_rst_x,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ-1:0]         i_req_we,
    input  logic [ADDR_W*N_REQ-1:0]  i_req_addr,
    input  logic [WDATA_W*N_REQ-1:0] i_req_wdata,
    input  logic [MASK_W*N_REQ-1:0]  i_req_mask,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic [N_REQ-1:0]         o_resp_valid,
    output logic [LINE_W-1:0]        o_resp_data,
    output logic [IDX_W-1:0]         o_gnt_idx,
    output logic                     o_timeout,
    output logic                     o_dram_rd_en,
    output logic                     o_dram_wr_en,
    output logic [ADDR_W-1:0]        o_dram_addr,
    output logic [WDATA_W-1:0]       o_dram_data,
    output logic [MASK_W-1:0]        o_dram_mask,
    input  logic [LINE_W-1:0]        i_dram_data,
    input  logic                     i_dram_busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_wcnt;
    logic                r_we;

    logic [N_REQ-1:0]    w_gnt_oh;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_any;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [WDATA_W-1:0]  w_wdata;
    logic [MASK_W-1:0]   w_mask;
    logic [CNT_W-1:0]    w_wcnt_inc;
    logic                w_done;

    dram_req_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_valid (i_req_valid),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt_oh),
        .o_idx   (w_gnt_idx),
        .o_any   (w_any)
    );

    // One-hot AND-OR select of the winner's payload
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_mask  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_addr  |= i_req_addr[k*ADDR_W +: ADDR_W]    & {ADDR_W{w_gnt_oh[k]}};
            w_wdata |= i_req_wdata[k*WDATA_W +: WDATA_W] & {WDATA_W{w_gnt_oh[k]}};
            w_mask  |= i_req_mask[k*MASK_W +: MASK_W]    & {MASK_W{w_gnt_oh[k]}};
        end
    end

    assign w_we       = |(i_req_we & w_gnt_oh);
    assign w_wcnt_inc = (r_wcnt == CNT_W'(TIMEOUT)) ? r_wcnt : r_wcnt + CNT_W'(1);
    // r_wcnt == 0 marks the first WAIT cycle, where busy may not have risen yet
    assign w_done     = (r_wcnt != '0) && !i_dram_busy;

    // Arbitration / command / completion FSM with all outputs registered
    always_ff @(posedge i_clk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            r_state      <= ST_IDLE;
            r_ptr        <= IDX_W'(N_REQ - 1);
            r_wcnt       <= '0;
            r_we         <= 1'b0;
            o_req_ready  <= '0;
            o_resp_valid <= '0;
            o_resp_data  <= '0;
            o_gnt_idx    <= '0;
            o_timeout    <= 1'b0;
            o_dram_rd_en <= 1'b0;
            o_dram_wr_en <= 1'b0;
            o_dram_addr  <= '0;
            o_dram_data  <= '0;
            o_dram_mask  <= '0;
        end else begin
            o_req_ready  <= '0;
            o_resp_valid <= '0;
            o_dram_rd_en <= 1'b0;
            o_dram_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any && !i_dram_busy) begin
                        o_req_ready <= w_gnt_oh;
                        o_gnt_idx   <= w_gnt_idx;
                        r_ptr       <= w_gnt_idx;
                        r_we        <= w_we;
                        o_dram_addr <= w_addr;
                        o_dram_data <= w_wdata;
                        o_dram_mask <= w_mask;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    o_dram_rd_en <= !r_we;
                    o_dram_wr_en <= r_we;
                    r_wcnt       <= '0;
                    r_state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wcnt <= w_wcnt_inc;
                    if (w_wcnt_inc == CNT_W'(TIMEOUT))
                        o_timeout <= 1'b1;
                    if (w_done) begin
                        o_resp_valid <= N_REQ'(1) << o_gnt_idx;
                        if (!r_we)
                            o_resp_data <= i_dram_data;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// tb_dram_req_arbiter: directed checks of grant, command, response, fairness, timeout and reset
module tb_dram_req_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst_x = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we = '0;
    logic [32*N-1:0] req_addr = '0;
    logic [32*N-1:0] req_wdata = '0;
    logic [4*N-1:0]  req_mask = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [127:0]    resp_data;
    logic [1:0]      gnt_idx;
    logic            timeout;
    logic            rd_en;
    logic            wr_en;
    logic [31:0]     dram_addr;
    logic [31:0]     dram_wdata;
    logic [3:0]      dram_mask;
    logic [127:0]    dram_line = '0;
    logic            busy;
    logic            calib = 1'b0;
    int              lat = 1;
    int              cnt = 0;
    int              n_chk = 0;
    int              n_pass = 0;

    localparam logic [127:0] LINE_A = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] LINE_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LINE_C = 128'hC0DE_C0DE_0000_0001_0000_0002_0000_0003;

    dram_req_arbiter #(
        .N_REQ   (N),
        .IDX_W   (2),
        .TIMEOUT (16)
    ) dut (
        .i_clk        (clk),
        .i_rst_x      (rst_x),
        .i_req_valid  (req_valid),
        .i_req_we     (req_we),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .i_req_mask   (req_mask),
        .o_req_ready  (req_ready),
        .o_resp_valid (resp_valid),
        .o_resp_data  (resp_data),
        .o_gnt_idx    (gnt_idx),
        .o_timeout    (timeout),
        .o_dram_rd_en (rd_en),
        .o_dram_wr_en (wr_en),
        .o_dram_addr  (dram_addr),
        .o_dram_data  (dram_wdata),
        .o_dram_mask  (dram_mask),
        .i_dram_data  (dram_line),
        .i_dram_busy  (busy)
    );

    always #5 clk = ~clk;

    // DRAM port model: busy for lat cycles after a command, forced high while calibrating
    assign busy = calib | (cnt != 0);
    always @(posedge clk or negedge rst_x) begin
        if (!rst_x) cnt <= 0;
        else if (rd_en | wr_en) cnt <= lat;
        else if (cnt != 0) cnt <= cnt - 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One isolated transaction from requester k; expects response lat+2 negedges after the enable
    task automatic run_one(input int k, input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, input int l, input logic [127:0] exp_line);
        int n;
        lat = l;
        req_we[k] = we;
        req_addr[k*32 +: 32] = a;
        req_wdata[k*32 +: 32] = d;
        req_mask[k*4 +: 4] = m;
        req_valid[k] = 1'b1;
        @(negedge clk);
        check("ready", 128'(req_ready), 128'(1) << k);
        check("gnt", 128'(gnt_idx), 128'(k));
        req_valid[k] = 1'b0;
        @(negedge clk);
        check("ready_pulse", 128'(req_ready), 128'(0));
        check("en", 128'({rd_en, wr_en}), 128'({!we, we}));
        check("cmd", 128'({dram_addr, dram_wdata, dram_mask}), 128'({a, d, m}));
        n = 0;
        while (resp_valid == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("resp_lat", 128'(n), 128'(l + 2));
        check("resp_valid", 128'(resp_valid), 128'(1) << k);
        check("resp_data", resp_data, exp_line);
        @(negedge clk);
        check("resp_pulse", 128'(resp_valid), 128'(0));
    endtask

    initial begin
        logic [N-1:0] seen;
        logic         seen_to;
        int           n;
        int           exp_rr [6] = '{1, 2, 0, 1, 2, 0};

        // reset while calibrating; requester 0 must wait for busy to drop
        calib = 1'b1;
        #1;
        check("rst_outs", 128'({req_ready, resp_valid, gnt_idx, timeout, rd_en, wr_en,
                                dram_addr, dram_wdata, dram_mask}), 128'(0));
        check("rst_line", resp_data, 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_x = 1'b1;
        req_addr[31:0] = 32'h0000_1000;
        req_valid[0] = 1'b1;
        seen = '0;
        repeat (6) begin
            @(negedge clk);
            seen |= req_ready;
        end
        check("calib_hold", 128'(seen), 128'(0));
        calib = 1'b0;
        dram_line = LINE_A;
        run_one(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 2, LINE_A);

        // write from requester 1: response data must not change
        dram_line = '1;
        run_one(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h0, 5, LINE_A);

        // read return from requester 0
        dram_line = LINE_B;
        run_one(0, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'hF, 3, LINE_B);
        check("gnt_hold", 128'(gnt_idx), 128'(0));

        // fairness: all held valid, last owner was 0
        lat = 1;
        for (int k = 0; k < N; k++) begin
            req_we[k] = 1'b0;
            req_addr[k*32 +: 32] = 32'h100 * (k + 1);
        end
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (req_ready == '0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("rr_order", 128'(req_ready), 128'(1) << exp_rr[i]);
            if (i == 5) req_valid = '0;
            @(negedge clk);
        end
        n = 0;
        while (resp_valid == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rr_last_resp", 128'(resp_valid), 128'(1));
        @(negedge clk);

        // timeout: busy stuck after the read command from requester 1
        lat = 1;
        req_we[1] = 1'b0;
        req_valid[1] = 1'b1;
        @(negedge clk);
        check("to_ready", 128'(req_ready), 128'(3'b010));
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("to_rd_en", 128'(rd_en), 128'(1));
        calib = 1'b1;
        seen_to = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen_to |= timeout;
        end
        check("to_early", 128'(seen_to), 128'(0));
        @(negedge clk);
        check("to_rise", 128'(timeout), 128'(1));
        repeat (4) @(negedge clk);
        check("to_still_wait", 128'({resp_valid, timeout}), 128'({3'b000, 1'b1}));
        calib = 1'b0;
        @(negedge clk);
        check("to_resp", 128'({resp_valid, timeout}), 128'({3'b010, 1'b1}));
        check("to_line", resp_data, LINE_B);
        repeat (3) @(negedge clk);
        check("to_sticky", 128'(timeout), 128'(1));

        // async reset in WAIT clears everything without a clock edge
        lat = 10;
        dram_line = LINE_C;
        req_we[0] = 1'b0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 128'(busy), 128'(1));
        #2 rst_x = 1'b0;
        #1;
        check("arst_outs", 128'({req_ready, resp_valid, gnt_idx, timeout, rd_en, wr_en,
                                 dram_addr, dram_wdata, dram_mask}), 128'(0));
        check("arst_line", resp_data, 128'(0));
        @(negedge clk);
        rst_x = 1'b1;
        @(negedge clk);
        run_one(2, 1'b0, 32'h0000_3000, 32'h0, 4'h3, 2, LINE_C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
